// File: rtl/sipo_frame_ctrl.sv
// ---------------------------------------------------------------------------
// sipo_frame_ctrl
//
// Serial-in / parallel-out frame receiver. A '1' on the idle line is taken
// as a start bit. The next WIDTH samples are shifted in MSB-first and the
// finished word is held on data_out until the consumer accepts it with
// data_ready.
//
// Optional feature macro: SIPO_FRAME_CTRL_PARITY_EN
//   When defined, one extra bit is sampled after the data bits. The data
//   bits plus that bit must have even parity. A failing frame is dropped
//   and frame_err pulses for one cycle. When undefined, frame_err is 0.
//
// Parameters
//   WIDTH       data bits per frame (2..16)
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous, active-high reset
//   data_in     serial line, sampled on every rising edge
//   data_ready  consumer accepts data_out while high (used in HOLD only)
//   data_out    assembled parallel word; changes only on entry to HOLD
//   data_valid  high while a complete, checked frame is held
//   busy        high while bits of a frame are being collected
//   frame_err   one-cycle pulse on a parity failure
//   overflow    sticky; set when a start bit arrives while holding a frame
// ---------------------------------------------------------------------------
module sipo_frame_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             data_in,
    input  logic             data_ready,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    output logic             busy,
    output logic             frame_err,
    output logic             overflow
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

`ifdef SIPO_FRAME_CTRL_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PARITY, HOLD} state_t;
`else
    typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;
`endif

    state_t            state;
    state_t            next_state;
    logic [CW-1:0]     bit_cnt;
    logic [WIDTH-1:0]  shreg;
    logic [WIDTH-1:0]  shifted;

    // Word as it will look after the current sample is shifted in.
    assign shifted = {shreg[WIDTH-2:0], data_in};

`ifdef SIPO_FRAME_CTRL_PARITY_EN
    logic parity_bad;
    logic frame_err_q;

    // Odd total over data bits plus the parity bit means a corrupted frame.
    assign parity_bad = ^{shreg, data_in};
    assign frame_err  = frame_err_q;
    assign busy       = (state == SHIFT) || (state == PARITY);
`else
    logic shreg_msb_unused;

    // The MSB only matters when the word is kept for a parity check.
    assign shreg_msb_unused = shreg[WIDTH-1];
    assign frame_err        = 1'b0;
    assign busy             = (state == SHIFT);
`endif

    assign data_valid = (state == HOLD);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (data_in) begin
                    next_state = SHIFT;
                end
            end
            SHIFT: begin
                if (bit_cnt == LAST_BIT) begin
`ifdef SIPO_FRAME_CTRL_PARITY_EN
                    next_state = PARITY;
`else
                    next_state = HOLD;
`endif
                end
            end
`ifdef SIPO_FRAME_CTRL_PARITY_EN
            PARITY: begin
                next_state = parity_bad ? IDLE : HOLD;
            end
`endif
            HOLD: begin
                // data_in is ignored on the transfer edge.
                if (data_ready) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Datapath: bit counter, shift register, output word and flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt  <= '0;
            shreg    <= '0;
            data_out <= '0;
            overflow <= 1'b0;
`ifdef SIPO_FRAME_CTRL_PARITY_EN
            frame_err_q <= 1'b0;
`endif
        end else begin
`ifdef SIPO_FRAME_CTRL_PARITY_EN
            frame_err_q <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (data_in) begin
                        bit_cnt <= '0;
                    end
                end
                SHIFT: begin
                    shreg   <= shifted;
                    bit_cnt <= bit_cnt + CW'(1);
`ifndef SIPO_FRAME_CTRL_PARITY_EN
                    if (bit_cnt == LAST_BIT) begin
                        data_out <= shifted;
                    end
`endif
                end
`ifdef SIPO_FRAME_CTRL_PARITY_EN
                PARITY: begin
                    if (parity_bad) begin
                        frame_err_q <= 1'b1;
                    end else begin
                        data_out <= shreg;
                    end
                end
`endif
                HOLD: begin
                    // A new frame arriving while one is still held is lost.
                    if (!data_ready && data_in) begin
                        overflow <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sipo_frame_ctrl
//
// Self-checking bench for sipo_frame_ctrl with WIDTH=4. It runs directed
// vectors with fixed expected values, then a randomized run that is compared
// against a frame-level reference model built on a queue of sampled bits.
// ---------------------------------------------------------------------------
module tb_sipo_frame_ctrl;

    localparam int W = 4;
`ifdef SIPO_FRAME_CTRL_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif

    logic         clk;
    logic         rst;
    logic         data_in;
    logic         data_ready;
    logic [W-1:0] data_out;
    logic         data_valid;
    logic         busy;
    logic         frame_err;
    logic         overflow;

    int compared;
    int mismatched;

    sipo_frame_ctrl #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
        .data_ready (data_ready),
        .data_out   (data_out),
        .data_valid (data_valid),
        .busy       (busy),
        .frame_err  (frame_err),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a frame is a list of collected bits; the word is
    // computed arithmetically once enough bits have arrived.
    bit           m_collect;
    bit           m_hold;
    bit           m_bits[$];
    logic [W-1:0] m_out;
    logic         m_err;
    logic         m_ovf;

    function automatic void modelStep(input logic r, input logic d, input logic y);
        int value;
        int ones;
        m_err = 1'b0;
        if (r) begin
            m_collect = 1'b0;
            m_hold    = 1'b0;
            m_bits.delete();
            m_out     = '0;
            m_ovf     = 1'b0;
        end else if (m_hold) begin
            if (y) begin
                m_hold = 1'b0;
            end else if (d) begin
                m_ovf = 1'b1;
            end
        end else if (m_collect) begin
            m_bits.push_back(d);
            if (m_bits.size() == W + P) begin
                value = 0;
                ones  = 0;
                for (int i = 0; i < W; i++) begin
                    value = value * 2 + int'(m_bits[i]);
                end
                for (int i = 0; i < W + P; i++) begin
                    ones = ones + int'(m_bits[i]);
                end
                m_collect = 1'b0;
                if (ones % 2 == 0 || P == 0) begin
                    m_hold = 1'b1;
                    m_out  = W'(value);
                end else begin
                    m_err = 1'b1;
                end
            end
        end else if (d) begin
            m_collect = 1'b1;
            m_bits.delete();
        end
    endfunction

    // Drive one cycle of inputs, let the edge happen, advance the model and
    // settle away from the edge.
    task automatic applyStimulus(input logic r, input logic d, input logic y);
        rst        = r;
        data_in    = d;
        data_ready = y;
        @(posedge clk);
        modelStep(r, d, y);
        #1;
    endtask

    task automatic checkOne(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %b, expected %b at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic checkOutput(input string tag, input logic [W-1:0] e_out, input logic e_valid,
                               input logic e_busy, input logic e_err, input logic e_ovf);
        checkOne({tag, ".data_out"}, data_out, e_out);
        checkOne({tag, ".data_valid"}, W'(data_valid), W'(e_valid));
        checkOne({tag, ".busy"}, W'(busy), W'(e_busy));
        checkOne({tag, ".frame_err"}, W'(frame_err), W'(e_err));
        checkOne({tag, ".overflow"}, W'(overflow), W'(e_ovf));
        if (data_valid && busy) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL %s.exclusive: data_valid and busy both high at %0t", tag, $time);
        end
    endtask

    typedef struct {
        logic         r;
        logic         d;
        logic         y;
        logic [W-1:0] out;
        logic         v;
        logic         b;
        logic         o;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic d, input logic y,
                                input logic [W-1:0] out, input logic v, input logic b,
                                input logic o);
        vec_t t;
        t.r = r; t.d = d; t.y = y; t.out = out; t.v = v; t.b = b; t.o = o;
        return t;
    endfunction

    vec_t tbl[$];

    initial begin
        compared   = 0;
        mismatched = 0;
        rst        = 1'b1;
        data_in    = 1'b0;
        data_ready = 1'b0;
        m_collect  = 1'b0;
        m_hold     = 1'b0;
        m_out      = '0;
        m_err      = 1'b0;
        m_ovf      = 1'b0;

`ifndef SIPO_FRAME_CTRL_PARITY_EN
        //          r  d  y  out      v  b  o
        tbl.push_back(mk(1, 0, 0, 4'b0000, 0, 0, 0));
        // Frame 1,0,0,1,0 with the consumer always ready.
        tbl.push_back(mk(0, 1, 1, 4'b0000, 0, 1, 0));
        tbl.push_back(mk(0, 0, 1, 4'b0000, 0, 1, 0));
        tbl.push_back(mk(0, 0, 1, 4'b0000, 0, 1, 0));
        tbl.push_back(mk(0, 1, 1, 4'b0000, 0, 1, 0));
        tbl.push_back(mk(0, 0, 1, 4'b0010, 1, 0, 0));
        tbl.push_back(mk(0, 0, 1, 4'b0010, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 4'b0010, 0, 0, 0));
        // Frame 1,1,0,1,1 held for three cycles before the consumer accepts.
        tbl.push_back(mk(0, 1, 0, 4'b0010, 0, 1, 0));
        tbl.push_back(mk(0, 1, 0, 4'b0010, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 4'b0010, 0, 1, 0));
        tbl.push_back(mk(0, 1, 0, 4'b0010, 0, 1, 0));
        tbl.push_back(mk(0, 1, 0, 4'b1011, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 4'b1011, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 4'b1011, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 4'b1011, 1, 0, 0));
        tbl.push_back(mk(0, 0, 1, 4'b1011, 0, 0, 0));
        // Frame 1,0,1,1,0, then a start bit while holding sets overflow.
        tbl.push_back(mk(0, 1, 0, 4'b1011, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 4'b1011, 0, 1, 0));
        tbl.push_back(mk(0, 1, 0, 4'b1011, 0, 1, 0));
        tbl.push_back(mk(0, 1, 0, 4'b1011, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 4'b0110, 1, 0, 0));
        tbl.push_back(mk(0, 1, 0, 4'b0110, 1, 0, 1));
        // Transfer edge ignores data_in; the next edge may start a frame.
        tbl.push_back(mk(0, 1, 1, 4'b0110, 0, 0, 1));
        tbl.push_back(mk(0, 1, 1, 4'b0110, 0, 1, 1));
        tbl.push_back(mk(0, 0, 1, 4'b0110, 0, 1, 1));
        tbl.push_back(mk(0, 1, 1, 4'b0110, 0, 1, 1));
        // Reset after the second data bit clears everything.
        tbl.push_back(mk(1, 1, 1, 4'b0000, 0, 0, 0));
        // Start bit on the first edge with rst low, frame 1,0,1,0,1.
        tbl.push_back(mk(0, 1, 1, 4'b0000, 0, 1, 0));
        tbl.push_back(mk(0, 0, 1, 4'b0000, 0, 1, 0));
        tbl.push_back(mk(0, 1, 1, 4'b0000, 0, 1, 0));
        tbl.push_back(mk(0, 0, 1, 4'b0000, 0, 1, 0));
        tbl.push_back(mk(0, 1, 1, 4'b0101, 1, 0, 0));
        tbl.push_back(mk(0, 0, 1, 4'b0101, 0, 0, 0));

        foreach (tbl[i]) begin
            applyStimulus(tbl[i].r, tbl[i].d, tbl[i].y);
            checkOutput($sformatf("vec%0d", i), tbl[i].out, tbl[i].v, tbl[i].b, 1'b0, tbl[i].o);
        end

        // Quiet line keeps the receiver idle.
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0);
            checkOutput("idle_line", 4'b0101, 1'b0, 1'b0, 1'b0, 1'b0);
        end
`else
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("par_reset", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        // Good frame: 1011 with parity bit 1 gives four ones in total.
        applyStimulus(1'b0, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput("par_in_parity", 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput("par_good", 4'b1011, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("par_taken", 4'b1011, 1'b0, 1'b0, 1'b0, 1'b0);
        // Bad frame: 1011 with parity bit 0 is dropped.
        applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("par_bad", 4'b1011, 1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("par_err_pulse", 4'b1011, 1'b0, 1'b0, 1'b0, 1'b0);
`endif

        // Randomized run against the reference model.
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("rand_reset", m_out, m_hold, m_collect, m_err, m_ovf);
        for (int i = 0; i < 3000; i++) begin
            applyStimulus(($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0,
                          1'($urandom_range(0, 1)),
                          ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0);
            checkOutput("rand", m_out, m_hold, m_collect, m_err, m_ovf);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/sipo_frame_ctrl.md
SIPO_FRAME_CTRL -- requirements
Module: sipo_frame_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 4, giving the number of data bits per frame (legal range 2..16).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port data_in, input, 1 bit: serial line, sampled on every rising clk edge.
REQ-005 SHALL have port data_ready, input, 1 bit: consumer accepts data_out while high.
REQ-006 SHALL have port data_out, output, WIDTH bits: the assembled parallel word.
REQ-007 SHALL have port data_valid, output, 1 bit: data_out holds a complete, checked frame.
REQ-008 SHALL have port busy, output, 1 bit: high in SHIFT and PARITY states.
REQ-009 SHALL have port frame_err, output, 1 bit: one-cycle pulse on a parity failure.
REQ-010 SHALL have port overflow, output, 1 bit: sticky flag for a frame lost while holding.

Function
REQ-011 SHALL implement states IDLE, SHIFT, PARITY (only with PARITY_EN) and HOLD.
REQ-012 IDLE: data_in==1 sampled SHALL be taken as the start bit; go to SHIFT, clear the bit counter; data_in==0 keeps IDLE.
REQ-013 SHIFT: each edge SHALL shift data_in into the LSB of the internal shift register, with the left shift moving the first data bit into the MSB.
REQ-014 SHIFT SHALL run for exactly WIDTH edges under a counter of width clog2(WIDTH+1).
- After the WIDTH-th bit: go to PARITY if PARITY_EN is defined, else to HOLD.
REQ-015 Without parity, data_valid SHALL rise after edge k+WIDTH, where edge k sampled the start bit.
- That is, WIDTH+1 cycles of latency from the start bit.
REQ-016 data_out SHALL update only on entry to HOLD.
- It SHALL keep its value in all other states, including after a transfer.
REQ-017 HOLD: data_valid SHALL stay high until an edge samples data_ready==1 (transfer); the next state is then IDLE.
REQ-018 On the transfer edge data_in SHALL be ignored.
- A start bit is recognised no earlier than the cycle after data_valid falls.
REQ-019 HOLD: data_in==1 sampled with data_ready==0 SHALL set overflow.
- The frame in HOLD is kept; the new frame is discarded.
REQ-020 overflow SHALL clear only on reset.
REQ-021 data_ready SHALL have no effect outside HOLD.
REQ-022 busy SHALL be high exactly in SHIFT and PARITY.
- data_valid and busy SHALL never be high together.

Reset
REQ-023 rst high at an edge SHALL force IDLE from any state, including mid-SHIFT, mid-PARITY and HOLD.
REQ-024 The same reset edge SHALL clear data_out to 0, data_valid, busy, frame_err and overflow to 0, and the bit counter and shift register to 0.
REQ-025 The first start bit SHALL be accepted on the first edge with rst low.

Configuration
REQ-026 Macro SIPO_FRAME_CTRL_PARITY_EN, when defined, SHALL add the PARITY state.
- PARITY samples one extra bit after the data bits.
- Even parity over the WIDTH data bits plus the parity bit SHALL yield HOLD.
- On mismatch: frame_err pulses high for one cycle, the frame is discarded, data_out is unchanged, and the next state is IDLE.
- data_valid latency becomes WIDTH+2 cycles.
REQ-027 Without SIPO_FRAME_CTRL_PARITY_EN there SHALL be no PARITY state, and frame_err SHALL be tied to 0.

Verification (WIDTH=4)
REQ-028 No parity, data_ready=1: data_in 1,0,0,1,0 on successive edges -> data_out=4'b0010 with data_valid high for exactly one cycle, on the cycle after the 5th edge.
REQ-029 No parity, data_ready=0 for 3 cycles after valid: data_in 1,1,0,1,1 then 0 -> data_out=4'b1011 held with data_valid high until the ready edge; overflow=0.
REQ-030 data_ready=0 in HOLD, data_in=1 sampled -> overflow=1 and data_out unchanged; after data_ready=1, overflow stays 1 until rst.
REQ-031 PARITY_EN: data_in 1,1,0,1,1,1 -> data_out=4'b1011 and data_valid; data_in 1,1,0,1,1,0 -> frame_err one-cycle pulse, no data_valid.
REQ-032 rst=1 on the edge after the 2nd data bit -> IDLE next cycle with all outputs 0; a following frame 1,0,1,0,1 -> data_out=4'b0101.
REQ-033 Idle line data_in=0 held for 20 cycles -> busy=0, data_valid=0 throughout.
